vga_downscaler: RTL and testbench

- Streaming 2:1 decimator: converts a 640x480 RGB444 pixel stream (camera / VGA-rate source) to a 320x240 QVGA stream.
- Each QVGA pixel is the 2x2 box average of its source block.
- Sits between the capture front end and the QVGA frame-buffer writer. Its output feeds the same frame buffer the display-side upscaler reads back.
- One half-line buffer, no backpressure: every output is a write strobe with its address.

---
 rtl/vga_downscaler.sv | 138 +++++++++++++
 tb/tb_vga_downscaler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_downscaler.sv
// vga_downscaler: 2:1 box-filter decimator, RGB444 stream to quarter size.
// Build option VGA_DOWNSCALE_ROUND_EN: round half up instead of truncating.
module vga_downscaler #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        sof,
  input  logic        pix_valid,
  input  logic [11:0] pix_data,
  output logic        out_valid,
  output logic [11:0] out_data,
  output logic [8:0]  out_x,
  output logic [7:0]  out_y,
  output logic        out_eol,
  output logic        out_eof
);

  localparam int XW = $clog2(SRC_WIDTH);
  localparam int YW = $clog2(SRC_HEIGHT);
  localparam int LW = SRC_WIDTH / 2;
  localparam int AW = (LW > 1) ? $clog2(LW) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(SRC_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_HEIGHT - 1);

  logic [XW-1:0] sx;
  logic [XW-1:0] cx;
  logic [XW-1:0] nx;
  logic [YW-1:0] sy;
  logic [YW-1:0] cy;
  logic [YW-1:0] ny;
  logic [11:0]   hold;
  logic [14:0]   linebuf [LW];
  logic [14:0]   lb_q;
  logic [14:0]   hsum;
  logic [AW-1:0] lb_addr;
  logic          x_odd;
  logic          y_odd;
  logic          emit;
  logic          at_eol;
  logic          at_eof;
  logic [11:0]   avg;

  function automatic logic [3:0] avg4(
    input logic [4:0] a,
    input logic [4:0] b
  );
    logic [5:0] v;
`ifdef VGA_DOWNSCALE_ROUND_EN
    logic [6:0] r;
`endif
    v = {1'b0, a} + {1'b0, b};
`ifdef VGA_DOWNSCALE_ROUND_EN
    r = {1'b0, v} + 7'd2;
    return (r[6:2] > 5'd15) ? 4'hF : r[5:2];
`else
    return v[5:2];
`endif
  endfunction

  // Effective position of this pixel (sof forces origin) and its successor
  always_comb begin
    cx = sx;
    cy = sy;
    if (sof) begin
      cx = '0;
      cy = '0;
    end
    nx = cx + XW'(1);
    ny = cy;
    if (cx == X_LAST) begin
      nx = '0;
      ny = (cy == Y_LAST) ? '0 : cy + YW'(1);
    end
  end

  assign x_odd   = cx[0];
  assign y_odd   = cy[0];
  assign emit    = pix_valid & x_odd & y_odd;
  assign at_eol  = (cx == X_LAST);
  assign at_eof  = at_eol & (cy == Y_LAST);
  assign lb_addr = AW'(cx >> 1);

  assign hsum = {
    {1'b0, hold[11:8]} + {1'b0, pix_data[11:8]},
    {1'b0, hold[7:4]}  + {1'b0, pix_data[7:4]},
    {1'b0, hold[3:0]}  + {1'b0, pix_data[3:0]}
  };

  assign avg = {
    avg4(hsum[14:10], lb_q[14:10]),
    avg4(hsum[9:5],   lb_q[9:5]),
    avg4(hsum[4:0],   lb_q[4:0])
  };

  // Source counters and even-column hold register
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sx   <= '0;
      sy   <= '0;
      hold <= '0;
    end else if (pix_valid) begin
      sx <= nx;
      sy <= ny;
      if (!x_odd) hold <= pix_data;
    end
  end

  // Half-line buffer: store on even rows, prefetch at even column of odd rows
  always_ff @(posedge vga_clk) begin
    if (pix_valid && x_odd && !y_odd) linebuf[lb_addr] <= hsum;
    if (pix_valid && !x_odd && y_odd) lb_q <= linebuf[lb_addr];
  end

  // Registered write strobe with averaged pixel and QVGA address
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= emit;
      out_eol   <= emit & at_eol;
      out_eof   <= emit & at_eof;
      if (emit) begin
        out_data <= avg;
        out_x    <= 9'(cx >> 1);
        out_y    <= 8'(cy >> 1);
      end
    end
  end

endmodule

// File: tb/tb_vga_downscaler.sv
// tb_vga_downscaler: directed checks of the 2:1 decimator.
// Uses a reduced 16x8 source frame so whole frames stay short.
module tb_vga_downscaler;

  localparam int W = 16;
  localparam int H = 8;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        sof;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        out_valid;
  logic [11:0] out_data;
  logic [8:0]  out_x;
  logic [7:0]  out_y;
  logic        out_eol;
  logic        out_eof;
  logic [30:0] obs_w;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 vga_clk = ~vga_clk;

  vga_downscaler #(
    .SRC_WIDTH (W),
    .SRC_HEIGHT(H)
  ) dut (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .sof      (sof),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_eol  (out_eol),
    .out_eof  (out_eof)
  );

  assign obs_w = {out_data, out_x, out_y, out_eol, out_eof};

  function automatic logic [11:0] pat(int m, int x, int y);
    logic [11:0] p;
    int r, g, b;
    r = x % 16;
    g = (y * 2 + 1) % 16;
    b = (x + y * 3) % 16;
    case (m)
      0: p = 12'hABC;
      1: p = {4'(r), 4'(g), 4'(b)};
      default: begin
        p = 12'h000;
        if (x == 0 && y == 0) p = 12'hF00;
        if (x == 0 && y == 1) p = 12'h0F0;
        if (x == 1 && y == 1) p = 12'h00F;
      end
    endcase
    return p;
  endfunction

  function automatic logic [11:0] exp_pix(int m, int bx, int by);
    logic [11:0] q [4];
    logic [11:0] o;
    int s, r;
    q[0] = pat(m, 2 * bx, 2 * by);
    q[1] = pat(m, 2 * bx + 1, 2 * by);
    q[2] = pat(m, 2 * bx, 2 * by + 1);
    q[3] = pat(m, 2 * bx + 1, 2 * by + 1);
    o = '0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(q[k][4*c +: 4]);
`ifdef VGA_DOWNSCALE_ROUND_EN
      r = (s + 2) / 4;
      if (r > 15) r = 15;
`else
      r = s / 4;
`endif
      o[4*c +: 4] = 4'(r);
    end
    return o;
  endfunction

  function automatic logic [30:0] exp_word(int m, int bx, int by);
    logic eol, eof;
    eol = (bx == W / 2 - 1);
    eof = eol && (by == H / 2 - 1);
    return {exp_pix(m, bx, by), 9'(bx), 8'(by), eol, eof};
  endfunction

  task automatic drive(input logic v, input logic s, input logic [11:0] d);
    pix_valid = v;
    sof       = s;
    pix_data  = d;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pix_valid = 1'b0;
    sof = 1'b0;
    pix_data = 12'h000;
    repeat (3) @(posedge vga_clk);
    #1;
    n_tot++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_valid got %b want 0", out_valid);
    else n_pass++;
    n_tot++;
    if (obs_w !== 31'h0)
      $display("FAIL reset_outs got %h want 0", obs_w);
    else n_pass++;
    reset = 1'b0;
    drive(1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_const_frame;
    int pulses;
    logic ev;
    pulses = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        drive(1'b1, x == 0 && y == 0, pat(0, x, y));
        ev = (x % 2 == 1) && (y % 2 == 1);
        if (out_valid) pulses++;
        n_tot++;
        if (out_valid !== ev)
          $display("FAIL const_valid x=%0d y=%0d got %b want %b", x, y, out_valid, ev);
        else n_pass++;
        if (ev) begin
          n_tot++;
          if (obs_w !== exp_word(0, x / 2, y / 2))
            $display("FAIL const_word x=%0d y=%0d got %h want %h", x, y, obs_w, exp_word(0, x / 2, y / 2));
          else n_pass++;
        end
      end
    n_tot++;
    if (pulses != W * H / 4)
      $display("FAIL const_pulses got %0d want %0d", pulses, W * H / 4);
    else n_pass++;
    drive(1'b0, 1'b0, 12'h000);
    n_tot++;
    if (out_valid !== 1'b0)
      $display("FAIL const_tail got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_block;
    logic ev;
    logic [11:0] want0;
`ifdef VGA_DOWNSCALE_ROUND_EN
    want0 = 12'h444;
`else
    want0 = 12'h333;
`endif
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        drive(1'b1, x == 0 && y == 0, pat(2, x, y));
        ev = (x % 2 == 1) && (y % 2 == 1);
        n_tot++;
        if (out_valid !== ev)
          $display("FAIL block_valid x=%0d y=%0d got %b want %b", x, y, out_valid, ev);
        else n_pass++;
        if (x == 1 && y == 1) begin
          n_tot++;
          if (out_data !== want0)
            $display("FAIL block_avg got %h want %h", out_data, want0);
          else n_pass++;
        end else if (ev) begin
          n_tot++;
          if (obs_w !== exp_word(2, x / 2, y / 2))
            $display("FAIL block_word x=%0d y=%0d got %h want %h", x, y, obs_w, exp_word(2, x / 2, y / 2));
          else n_pass++;
        end
      end
  endtask

  task automatic test_gaps;
    logic ev;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        for (int g = 0; g < 4 && $urandom_range(0, 99) < 30; g++) begin
          drive(1'b0, 1'b0, 12'h5A5);
          n_tot++;
          if (out_valid !== 1'b0)
            $display("FAIL gap_valid x=%0d y=%0d got %b want 0", x, y, out_valid);
          else n_pass++;
        end
        drive(1'b1, x == 0 && y == 0, pat(1, x, y));
        ev = (x % 2 == 1) && (y % 2 == 1);
        n_tot++;
        if (out_valid !== ev)
          $display("FAIL gaps_valid x=%0d y=%0d got %b want %b", x, y, out_valid, ev);
        else n_pass++;
        if (ev) begin
          n_tot++;
          if (obs_w !== exp_word(1, x / 2, y / 2))
            $display("FAIL gaps_word x=%0d y=%0d got %h want %h", x, y, obs_w, exp_word(1, x / 2, y / 2));
          else n_pass++;
        end
      end
  endtask

  task automatic test_frame_wrap;
    logic ev;
    for (int f = 0; f < 3; f++)
      for (int y = 0; y < ((f == 2) ? 2 : H); y++)
        for (int x = 0; x < W; x++) begin
          drive(1'b1, f == 0 && x == 0 && y == 0, pat(1, x, y));
          ev = (x % 2 == 1) && (y % 2 == 1);
          n_tot++;
          if (out_valid !== ev)
            $display("FAIL wrap_valid f=%0d x=%0d y=%0d got %b want %b", f, x, y, out_valid, ev);
          else n_pass++;
          if (ev) begin
            n_tot++;
            if (obs_w !== exp_word(1, x / 2, y / 2))
              $display("FAIL wrap_word f=%0d x=%0d y=%0d got %h want %h", f, x, y, obs_w, exp_word(1, x / 2, y / 2));
            else n_pass++;
          end
        end
  endtask

  task automatic test_sof_mid;
    logic ev;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < W; x++) begin
        if (y == 3 && x == 5) break;
        drive(1'b1, x == 0 && y == 0, pat(1, x, y));
      end
    drive(1'b1, 1'b1, pat(0, 0, 0));
    n_tot++;
    if (out_valid !== 1'b0)
      $display("FAIL sof_cut got %b want 0", out_valid);
    else n_pass++;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++) begin
        if (y == 0 && x == 0) continue;
        drive(1'b1, 1'b0, pat(0, x, y));
        ev = (x % 2 == 1) && (y % 2 == 1);
        n_tot++;
        if (out_valid !== ev)
          $display("FAIL sof_valid x=%0d y=%0d got %b want %b", x, y, out_valid, ev);
        else n_pass++;
        if (ev) begin
          n_tot++;
          if (obs_w !== exp_word(0, x / 2, y / 2))
            $display("FAIL sof_word x=%0d y=%0d got %h want %h", x, y, obs_w, exp_word(0, x / 2, y / 2));
          else n_pass++;
        end
      end
  endtask

  task automatic test_reset_mid;
    logic ev;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++) begin
        if (y == 1 && x == 4) break;
        drive(1'b1, x == 0 && y == 0, pat(1, x, y));
      end
    n_tot++;
    if ({out_valid, obs_w} !== {1'b1, exp_word(1, 1, 0)})
      $display("FAIL rmid_pre got %b/%h want 1/%h", out_valid, obs_w, exp_word(1, 1, 0));
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_tot++;
    if ({out_valid, obs_w} !== 32'h0)
      $display("FAIL rmid_async got %b/%h want 0/0", out_valid, obs_w);
    else n_pass++;
    #1 reset = 1'b0;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++) begin
        drive(1'b1, 1'b0, pat(1, x, y));
        ev = (x % 2 == 1) && (y % 2 == 1);
        n_tot++;
        if (out_valid !== ev)
          $display("FAIL rmid_valid x=%0d y=%0d got %b want %b", x, y, out_valid, ev);
        else n_pass++;
        if (ev) begin
          n_tot++;
          if (obs_w !== exp_word(1, x / 2, y / 2))
            $display("FAIL rmid_word x=%0d y=%0d got %h want %h", x, y, obs_w, exp_word(1, x / 2, y / 2));
          else n_pass++;
        end
      end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_const_frame();
    test_block();
    test_gaps();
    test_frame_wrap();
    test_sof_mid();
    test_reset_mid();
    drive(1'b0, 1'b0, 12'h000);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
